wb_queue: RTL and testbench

- Writeback queue between the execution units (ALU, load unit) and the register file write port.
- Buffers completed results (destination, data) from a valid/ready producer interface and drains one entry per cycle onto the register file write port (reg_write/rd/rd_data).
- Provides a pending-write lookup on two source indices so issue logic can detect and forward results not yet committed.

---
 rtl/wb_queue.sv | 168 ++++++++++++++++
 tb/tb_wb_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: writeback queue between the execution units and the register file.
// Completed results (rd, data) are accepted on a valid/ready port, held in a
// circular buffer, and drained one per cycle onto the register-file write
// port unless wb_hold is high. Two lookup ports report whether a queued write
// targets a source index and return the youngest queued data for it.
//
// Optional build macro: WB_BYPASS_EN
//   When defined, a result arriving while the queue is empty and not held is
//   written straight through in the same cycle. A full queue also accepts a
//   new result when it is draining that cycle.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_rd,
  input  logic [15:0]      in_data,
  input  logic             wb_hold,
  output logic             reg_write,
  output logic [3:0]       rd,
  output logic [15:0]      rd_data,
  input  logic [3:0]       rs1,
  input  logic [3:0]       rs2,
  output logic             rs1_pend,
  output logic             rs2_pend,
  output logic [15:0]      rs1_fwd,
  output logic [15:0]      rs2_fwd,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Entry storage, one register pair per slot.
  logic [3:0]       ent_rd_q   [DEPTH];
  logic [15:0]      ent_data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             store;
  logic             write_thru;

  // Per-slot liveness and lookup matches, and slot index ordered by age.
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic [PTR_W-1:0] age_slot [DEPTH];

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = !empty && !wb_hold;

`ifdef WB_BYPASS_EN
  // An empty, undelayed queue passes a real result straight to the port;
  // a full queue that drains this cycle frees the slot the push will take.
  assign write_thru = empty && !wb_hold && in_valid && (in_rd != 4'd0);
  assign in_ready   = !full || !wb_hold;
`else
  assign write_thru = 1'b0;
  assign in_ready   = !full;
`endif

  // Index 0 writes are accepted but dropped; write-through results are never stored.
  assign push  = in_valid && in_ready;
  assign store = push && (in_rd != 4'd0) && !write_thru;

  assign count = count_q;

  // Write port: head entry when draining, otherwise the write-through result.
  always_comb begin
    reg_write = pop || write_thru;
    rd        = 4'd0;
    rd_data   = 16'd0;
    if (pop) begin
      rd      = ent_rd_q[head_q];
      rd_data = ent_data_q[head_q];
    end else if (write_thru) begin
      rd      = in_rd;
      rd_data = in_data;
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    if (store) begin
      tail_d = tail_q + PTR_ONE;
    end
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi);
      logic [PTR_W-1:0] age;

      // Distance from the head tells whether this slot currently holds data.
      assign age         = SLOT - head_q;
      assign live[gi]    = ({1'b0, age} < count_q);
      assign match1[gi]  = live[gi] && (ent_rd_q[gi] == rs1) && (rs1 != 4'd0);
      assign match2[gi]  = live[gi] && (ent_rd_q[gi] == rs2) && (rs2 != 4'd0);
      assign age_slot[gi] = head_q + SLOT;

      // Slot storage: written only when the tail points here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_rd_q[gi]   <= 4'd0;
          ent_data_q[gi] <= 16'd0;
        end else if (store && (tail_q == SLOT)) begin
          ent_rd_q[gi]   <= in_rd;
          ent_data_q[gi] <= in_data;
        end
      end
    end
  endgenerate

  // Lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    rs1_fwd  = 16'd0;
    rs2_fwd  = 16'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[age_slot[k]]) begin
        rs1_pend = 1'b1;
        rs1_fwd  = ent_data_q[age_slot[k]];
      end
      if (match2[age_slot[k]]) begin
        rs2_pend = 1'b1;
        rs2_fwd  = ent_data_q[age_slot[k]];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed vector table, hand-written reset/stream sequences and
// a randomized run checked against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [15:0] in_data;
  logic        wb_hold;
  logic        reg_write;
  logic [3:0]  rd;
  logic [15:0] rd_data;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        rs1_pend;
  logic        rs2_pend;
  logic [15:0] rs1_fwd;
  logic [15:0] rs2_fwd;
  logic [PTR_W:0] count;

  int total = 0;
  int bad   = 0;

  wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wb_hold   (wb_hold),
    .reg_write (reg_write),
    .rd        (rd),
    .rd_data   (rd_data),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .rs1_fwd   (rs1_fwd),
    .rs2_fwd   (rs2_fwd),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [3:0]  ird;
    logic [15:0] idata;
    logic        hold;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        e_rdy;
    logic        e_wr;
    logic [3:0]  e_rd;
    logic [15:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_p1;
    logic [15:0] e_f1;
    logic        e_p2;
    logic [15:0] e_f2;
  } vec_t;

  vec_t vt[$];

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  ent_t mq[$];

  function automatic void add(input logic v, input logic [3:0] ird, input logic [15:0] idata,
                              input logic hold, input logic [3:0] r1, input logic [3:0] r2,
                              input logic e_rdy, input logic e_wr, input logic [3:0] e_rd,
                              input logic [15:0] e_data, input logic [2:0] e_cnt,
                              input logic e_p1, input logic [15:0] e_f1,
                              input logic e_p2, input logic [15:0] e_f2);
    vec_t t;
    t.v = v; t.ird = ird; t.idata = idata; t.hold = hold; t.r1 = r1; t.r2 = r2;
    t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_rd = e_rd; t.e_data = e_data; t.e_cnt = e_cnt;
    t.e_p1 = e_p1; t.e_f1 = e_f1; t.e_p2 = e_p2; t.e_f2 = e_f2;
    vt.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ird, input logic [15:0] idata,
                       input logic h, input logic [3:0] a, input logic [3:0] b);
    in_valid = v; in_rd = ird; in_data = idata; wb_hold = h; rs1 = a; rs2 = b;
  endtask

  // Reference lookup: youngest stored entry matching idx.
  task automatic model_lookup(input logic [3:0] idx, output logic pend, output logic [15:0] fwd);
    pend = 1'b0;
    fwd  = 16'd0;
    if (idx != 4'd0) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if (mq[j].rd == idx) begin
          pend = 1'b1;
          fwd  = mq[j].data;
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
  endtask

  initial begin
    logic        m_rdy, m_wt, m_pop, m_wr, p1, p2;
    logic [3:0]  m_rd;
    logic [15:0] m_data, f1, f2;
    int          n;

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd3, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset reg_write", reg_write, 0);
    chk("reset rd", rd, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset count", count, 0);
    chk("reset rs1_pend", rs1_pend, 0);
    chk("reset rs2_fwd", rs2_fwd, 0);
    rst_n = 1'b1;

`ifndef WB_BYPASS_EN
    //   v  ird   idata       hold r1    r2    rdy wr rd    data        cnt  p1 f1          p2 f2
    add(1, 4'd3, 16'hABCD,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd3, 4'd0, 1,  1, 4'd3, 16'hABCD,   1,   1, 16'hABCD,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd3, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd1, 16'h0011,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd2, 16'h0022,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   1,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd3, 16'h0033,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   2,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd4, 16'h0044,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   3,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd5, 16'h0055,   1,   4'd4, 4'd1, 0,  0, 4'd0, 16'h0000,   4,   1, 16'h0044,   1, 16'h0011);
    add(0, 4'd0, 16'h0000,   0,   4'd5, 4'd0, 0,  1, 4'd1, 16'h0011,   4,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  1, 4'd2, 16'h0022,   3,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  1, 4'd3, 16'h0033,   2,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  1, 4'd4, 16'h0044,   1,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd5, 16'h0001,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd5, 16'h0002,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   1,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   1,   4'd5, 4'd0, 1,  0, 4'd0, 16'h0000,   2,   1, 16'h0002,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd5, 4'd0, 1,  1, 4'd5, 16'h0001,   2,   1, 16'h0002,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd5, 4'd5, 1,  1, 4'd5, 16'h0002,   1,   1, 16'h0002,   1, 16'h0002);
    add(0, 4'd0, 16'h0000,   0,   4'd5, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd0, 16'hFFFF,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
`else
    add(1, 4'd9, 16'h1234,   0,   4'd9, 4'd0, 1,  1, 4'd9, 16'h1234,   0,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd1, 16'h0011,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd2, 16'h0022,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   1,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd3, 16'h0033,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   2,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd4, 16'h0044,   1,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   3,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd7, 16'h0077,   1,   4'd0, 4'd0, 0,  0, 4'd0, 16'h0000,   4,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd6, 16'h0066,   0,   4'd0, 4'd0, 1,  1, 4'd1, 16'h0011,   4,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd6, 4'd7, 1,  1, 4'd2, 16'h0022,   4,   1, 16'h0066,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  1, 4'd3, 16'h0033,   3,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  1, 4'd4, 16'h0044,   2,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  1, 4'd6, 16'h0066,   1,   0, 16'h0000,   0, 16'h0000);
    add(0, 4'd0, 16'h0000,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
    add(1, 4'd0, 16'hFFFF,   0,   4'd0, 4'd0, 1,  0, 4'd0, 16'h0000,   0,   0, 16'h0000,   0, 16'h0000);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].v, vt[i].ird, vt[i].idata, vt[i].hold, vt[i].r1, vt[i].r2);
      @(negedge clk);
      $display("vec %0d: ready=%b wr=%b rd=%0d data=%h count=%0d", i, in_ready, reg_write, rd, rd_data, count);
      chk($sformatf("vec%0d in_ready", i), in_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d reg_write", i), reg_write, vt[i].e_wr);
      chk($sformatf("vec%0d rd", i), rd, vt[i].e_rd);
      chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].e_data);
      chk($sformatf("vec%0d count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d rs1_pend", i), rs1_pend, vt[i].e_p1);
      chk($sformatf("vec%0d rs1_fwd", i), rs1_fwd, vt[i].e_f1);
      chk($sformatf("vec%0d rs2_pend", i), rs2_pend, vt[i].e_p2);
      chk($sformatf("vec%0d rs2_fwd", i), rs2_fwd, vt[i].e_f2);
      @(posedge clk);
      #1;
    end

    // Steady stream of rd=7 results, one per cycle, then reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'd7, 16'h0100 + 16'(i), 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      $display("stream %0d: wr=%b rd=%0d data=%h count=%0d", i, reg_write, rd, rd_data, count);
`ifdef WB_BYPASS_EN
      chk($sformatf("stream%0d reg_write", i), reg_write, 1);
      chk($sformatf("stream%0d rd_data", i), rd_data, 16'h0100 + 16'(i));
      chk($sformatf("stream%0d count", i), count, 0);
`else
      chk($sformatf("stream%0d reg_write", i), reg_write, (i > 0) ? 1 : 0);
      chk($sformatf("stream%0d rd_data", i), rd_data, (i > 0) ? 16'h0100 + 16'(i - 1) : 16'h0000);
      chk($sformatf("stream%0d count", i), count, (i > 0) ? 1 : 0);
`endif
      @(posedge clk);
      #1;
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd7, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset reg_write", reg_write, 0);
    chk("midreset count", count, 0);
    chk("midreset rd_data", rd_data, 0);
    chk("midreset rs1_pend", rs1_pend, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("post-reset %0d: wr=%b count=%0d", i, reg_write, count);
      chk($sformatf("postreset%0d reg_write", i), reg_write, 0);
      chk($sformatf("postreset%0d count", i), count, 0);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the queue model.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 4'($urandom_range(0, 5)), 16'($urandom),
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      n     = mq.size();
      m_rdy = (n != DEPTH);
`ifdef WB_BYPASS_EN
      m_rdy = m_rdy || !wb_hold;
      m_wt  = (n == 0) && !wb_hold && in_valid && (in_rd != 4'd0);
`else
      m_wt  = 1'b0;
`endif
      m_pop  = (n != 0) && !wb_hold;
      m_wr   = m_pop || m_wt;
      m_rd   = m_pop ? mq[0].rd   : (m_wt ? in_rd   : 4'd0);
      m_data = m_pop ? mq[0].data : (m_wt ? in_data : 16'd0);
      model_lookup(rs1, p1, f1);
      model_lookup(rs2, p2, f2);
      @(negedge clk);
      if (reg_write) $display("rand %0d: write rd=%0d data=%h count=%0d", cyc, rd, rd_data, count);
      chk("rand in_ready", in_ready, m_rdy);
      chk("rand reg_write", reg_write, m_wr);
      chk("rand rd", rd, m_rd);
      chk("rand rd_data", rd_data, m_data);
      chk("rand count", count, 16'(n));
      chk("rand rs1_pend", rs1_pend, p1);
      chk("rand rs1_fwd", rs1_fwd, f1);
      chk("rand rs2_pend", rs2_pend, p2);
      chk("rand rs2_fwd", rs2_fwd, f2);
      @(posedge clk);
      if (m_pop) void'(mq.pop_front());
      if (in_valid && m_rdy && (in_rd != 4'd0) && !m_wt) mq.push_back('{rd: in_rd, data: in_data});
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
